// File: rtl/pipeline_mem_arbiter_pkg.sv
// Shared types for the I/D memory port arbiter.
// Optional feature macro: ARB_PERF_CNT_EN (grant/conflict performance counters).
package pipeline_mem_arbiter_pkg;

    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned DATA_W    = 128;
    localparam int unsigned ARB_CNT_W = 16;

    typedef logic [ADDR_W-1:0] lc3b_word;
    typedef logic [DATA_W-1:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_I = 1'b0,
        ARB_D = 1'b1
    } arb_port_t;

    // Transaction presented on the physical memory port.
    typedef struct packed {
        logic     read;
        logic     write;
        lc3b_word address;
        lc3b_line wdata;
    } pmem_req_t;

endpackage

// File: rtl/pipeline_mem_arbiter_if.sv
// Bus bundle between the pipeline (imem/dmem), the arbiter and the physical memory port.
// Optional feature macro: ARB_PERF_CNT_EN adds the performance counter outputs.
interface pipeline_mem_arbiter_if
`ifdef ARB_PERF_CNT_EN
    #(parameter int unsigned CNT_W = pipeline_mem_arbiter_pkg::ARB_CNT_W)
`endif
    ;
    import pipeline_mem_arbiter_pkg::*;

    logic     i_mem_read;
    lc3b_word i_mem_address;
    lc3b_line i_mem_rdata;
    logic     i_mem_resp;

    logic     d_mem_read;
    logic     d_mem_write;
    lc3b_word d_mem_address;
    lc3b_line d_mem_wdata;
    lc3b_line d_mem_rdata;
    logic     d_mem_resp;

    logic     pmem_read;
    logic     pmem_write;
    lc3b_word pmem_address;
    lc3b_line pmem_wdata;
    lc3b_line pmem_rdata;
    logic     pmem_resp;

`ifdef ARB_PERF_CNT_EN
    logic [CNT_W-1:0] perf_i_grants;
    logic [CNT_W-1:0] perf_d_grants;
    logic [CNT_W-1:0] perf_conflicts;
`endif

    // Requesters and physical memory side.
    modport master (
`ifdef ARB_PERF_CNT_EN
        input  perf_i_grants, perf_d_grants, perf_conflicts,
`endif
        output i_mem_read, i_mem_address,
        input  i_mem_rdata, i_mem_resp,
        output d_mem_read, d_mem_write, d_mem_address, d_mem_wdata,
        input  d_mem_rdata, d_mem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

    // Arbiter side.
    modport slave (
`ifdef ARB_PERF_CNT_EN
        output perf_i_grants, perf_d_grants, perf_conflicts,
`endif
        input  i_mem_read, i_mem_address,
        output i_mem_rdata, i_mem_resp,
        input  d_mem_read, d_mem_write, d_mem_address, d_mem_wdata,
        output d_mem_rdata, d_mem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/pipeline_mem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
module pipeline_mem_arbiter_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] out
);

    // Count up on inc, hold at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out <= '0;
        end else if (inc && (out != {CNT_W{1'b1}})) begin
            out <= out + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_mem_arbiter.sv
// Shares one physical memory port between fetch (I, read-only) and MEM stage (D, read/write).
// Optional feature macro: ARB_PERF_CNT_EN adds saturating grant/conflict counters.
module pipeline_mem_arbiter
    import pipeline_mem_arbiter_pkg::*;
`ifdef ARB_PERF_CNT_EN
    #(parameter int unsigned CNT_W = ARB_CNT_W)
`endif
(
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_mem_arbiter_if.slave bus
);

    arb_state_t state, state_nxt;
    arb_port_t  last_grant, last_grant_nxt;
    pmem_req_t  pmem_req_c;
    logic       i_req_c;
    logic       d_req_c;

    assign i_req_c = bus.i_mem_read;
    assign d_req_c = bus.d_mem_read | bus.d_mem_write;

    // State and fairness register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= ARB_I;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Grant selection, transaction forwarding and response routing.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        pmem_req_c     = '0;
        bus.i_mem_resp = 1'b0;
        bus.d_mem_resp = 1'b0;
        case (state)
            IDLE: begin
                // On contention the port not served last goes next; stale pmem_resp is ignored here.
                if (d_req_c && (!i_req_c || (last_grant == ARB_I))) begin
                    state_nxt      = SERVE_D;
                    last_grant_nxt = ARB_D;
                end else if (i_req_c) begin
                    state_nxt      = SERVE_I;
                    last_grant_nxt = ARB_I;
                end
            end
            SERVE_I: begin
                pmem_req_c.read    = bus.i_mem_read;
                pmem_req_c.address = bus.i_mem_address;
                if (bus.pmem_resp) begin
                    bus.i_mem_resp = 1'b1;
                    state_nxt      = IDLE;
                end
            end
            SERVE_D: begin
                pmem_req_c.read    = bus.d_mem_read;
                pmem_req_c.write   = bus.d_mem_write;
                pmem_req_c.address = bus.d_mem_address;
                pmem_req_c.wdata   = bus.d_mem_wdata;
                if (bus.pmem_resp) begin
                    bus.d_mem_resp = 1'b1;
                    state_nxt      = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.pmem_read    = pmem_req_c.read;
    assign bus.pmem_write   = pmem_req_c.write;
    assign bus.pmem_address = pmem_req_c.address;
    assign bus.pmem_wdata   = pmem_req_c.wdata;

    // Read data is broadcast; each side qualifies it with its own resp.
    assign bus.i_mem_rdata = bus.pmem_rdata;
    assign bus.d_mem_rdata = bus.pmem_rdata;

`ifdef ARB_PERF_CNT_EN
    logic i_grant_c;
    logic d_grant_c;
    logic conflict_c;

    assign i_grant_c  = (state == IDLE) && (state_nxt == SERVE_I);
    assign d_grant_c  = (state == IDLE) && (state_nxt == SERVE_D);
    assign conflict_c = (state == IDLE) && i_req_c && d_req_c;

    pipeline_mem_arbiter_sat_counter #(.CNT_W(CNT_W)) u_cnt_i_grants (
        .clk(clk), .rst_n(rst_n), .inc(i_grant_c), .out(bus.perf_i_grants)
    );
    pipeline_mem_arbiter_sat_counter #(.CNT_W(CNT_W)) u_cnt_d_grants (
        .clk(clk), .rst_n(rst_n), .inc(d_grant_c), .out(bus.perf_d_grants)
    );
    pipeline_mem_arbiter_sat_counter #(.CNT_W(CNT_W)) u_cnt_conflicts (
        .clk(clk), .rst_n(rst_n), .inc(conflict_c), .out(bus.perf_conflicts)
    );
`endif

    // Protocol violations by the requesters or the memory.
    a_d_rw_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.d_mem_read && bus.d_mem_write));
    a_i_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (state == SERVE_I) |-> bus.i_mem_read);
    a_d_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (state == SERVE_D) |-> (bus.d_mem_read || bus.d_mem_write));
    // The first cycle after reset may still see a response from an aborted transaction.
    a_no_stale_resp: assert property (@(posedge clk) disable iff (!rst_n)
        ((state == IDLE) && $past(rst_n)) |-> !bus.pmem_resp);

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Testbench for pipeline_mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level ownership model.
module tb_pipeline_mem_arbiter;

    localparam int unsigned TB_CNT_W = 2;
    localparam int          CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

`ifdef ARB_PERF_CNT_EN
    pipeline_mem_arbiter_if #(.CNT_W(TB_CNT_W)) ifc ();
    pipeline_mem_arbiter #(.CNT_W(TB_CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));
`else
    pipeline_mem_arbiter_if ifc ();
    pipeline_mem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(ifc));
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Model: who owns the memory port (0 none, 1 I, 2 D) and who was served last.
    int m_owner = 0;
    int m_last  = 1;
    int m_i_gr  = 0;
    int m_d_gr  = 0;
    int m_conf  = 0;

    // Outputs observed in the most recent cycle.
    logic         obs_pr, obs_pw, obs_i_resp, obs_d_resp;
    logic [15:0]  obs_addr;
    logic [127:0] obs_wdata, obs_i_rdata;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, expv);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Check one cycle at the falling edge, then advance the model across the rising edge.
    task automatic step();
        logic         e_pr, e_pw, e_ir, e_dr;
        logic [15:0]  e_addr;
        logic [127:0] e_wd;
        @(negedge clk);
        obs_pr      = ifc.pmem_read;
        obs_pw      = ifc.pmem_write;
        obs_addr    = ifc.pmem_address;
        obs_wdata   = ifc.pmem_wdata;
        obs_i_resp  = ifc.i_mem_resp;
        obs_d_resp  = ifc.d_mem_resp;
        obs_i_rdata = ifc.i_mem_rdata;
        e_pr = 1'b0; e_pw = 1'b0; e_addr = '0; e_wd = '0;
        if (m_owner == 1) begin
            e_pr   = ifc.i_mem_read;
            e_addr = ifc.i_mem_address;
        end else if (m_owner == 2) begin
            e_pr   = ifc.d_mem_read;
            e_pw   = ifc.d_mem_write;
            e_addr = ifc.d_mem_address;
            e_wd   = ifc.d_mem_wdata;
        end
        e_ir = (m_owner == 1) && ifc.pmem_resp;
        e_dr = (m_owner == 2) && ifc.pmem_resp;
        chk("pmem_read",    128'(obs_pr),   128'(e_pr));
        chk("pmem_write",   128'(obs_pw),   128'(e_pw));
        chk("pmem_address", 128'(obs_addr), 128'(e_addr));
        chk("pmem_wdata",   obs_wdata,      e_wd);
        chk("i_mem_resp",   128'(obs_i_resp), 128'(e_ir));
        chk("d_mem_resp",   128'(obs_d_resp), 128'(e_dr));
        chk("i_mem_rdata",  obs_i_rdata,    ifc.pmem_rdata);
        chk("d_mem_rdata",  ifc.d_mem_rdata, ifc.pmem_rdata);
`ifdef ARB_PERF_CNT_EN
        chk("perf_i_grants",  128'(ifc.perf_i_grants),  128'(m_i_gr));
        chk("perf_d_grants",  128'(ifc.perf_d_grants),  128'(m_d_gr));
        chk("perf_conflicts", 128'(ifc.perf_conflicts), 128'(m_conf));
`endif
        @(posedge clk);
        if (!rst_n) begin
            m_owner = 0; m_last = 1; m_i_gr = 0; m_d_gr = 0; m_conf = 0;
        end else if (m_owner != 0) begin
            if (ifc.pmem_resp) m_owner = 0;
        end else begin
            bit ir, dr;
            ir = ifc.i_mem_read;
            dr = ifc.d_mem_read || ifc.d_mem_write;
            if (ir && dr) begin
                if (m_conf < CNT_MAX) m_conf++;
                m_owner = (m_last == 1) ? 2 : 1;
            end else if (dr) begin
                m_owner = 2;
            end else if (ir) begin
                m_owner = 1;
            end
            if (m_owner == 1 && m_i_gr < CNT_MAX) m_i_gr++;
            if (m_owner == 2 && m_d_gr < CNT_MAX) m_d_gr++;
            if (m_owner != 0) m_last = m_owner;
        end
        #1;
    endtask

    task automatic wait_strobe(output int waited);
        waited = 0;
        while (!(ifc.pmem_read || ifc.pmem_write) && waited < 20) begin
            step();
            waited++;
        end
        if (waited >= 20) chk("strobe_timeout", 128'(0), 128'(1));
    endtask

    // Wait for a grant, answer after lat cycles; returns idle cycles waited and granted address.
    task automatic serve(input int lat, input logic [127:0] rd, output int waited,
                         output logic [15:0] gaddr);
        wait_strobe(waited);
        gaddr = ifc.pmem_address;
        repeat (lat - 1) step();
        ifc.pmem_resp  = 1'b1;
        ifc.pmem_rdata = rd;
        step();
        ifc.pmem_resp = 1'b0;
    endtask

    initial begin
        int          w;
        int          wait_left;
        bit          allow_new;
        logic [15:0] ga;
        logic [127:0] rd;

        // Test 1: reset with both requesting, then D wins first.
        rst_n = 1'b0;
        ifc.i_mem_read = 1'b1; ifc.i_mem_address = 16'h1000;
        ifc.d_mem_read = 1'b1; ifc.d_mem_write = 1'b0;
        ifc.d_mem_address = 16'h2100; ifc.d_mem_wdata = '0;
        ifc.pmem_resp = 1'b0; ifc.pmem_rdata = '0;
        @(posedge clk); #1;
        step(); step();
        chk("rst_pmem_read",  128'(obs_pr),     128'(0));
        chk("rst_pmem_write", 128'(obs_pw),     128'(0));
        chk("rst_addr",       128'(obs_addr),   128'(0));
        chk("rst_wdata",      obs_wdata,        128'(0));
        chk("rst_i_resp",     128'(obs_i_resp), 128'(0));
        chk("rst_d_resp",     128'(obs_d_resp), 128'(0));
        rst_n = 1'b1;
        step(); step();
        chk("t1_first_d_read", 128'(obs_pr),   128'(1));
        chk("t1_first_d_addr", 128'(obs_addr), 128'(16'h2100));
        serve(1, rnd128(), w, ga);
        ifc.d_mem_read = 1'b0;
        serve(2, rnd128(), w, ga);
        chk("t1_then_i_addr", 128'(ga), 128'(16'h1000));
        ifc.i_mem_read = 1'b0;
        step();

        // Test 3: D write.
        ifc.d_mem_write = 1'b1; ifc.d_mem_address = 16'h2002;
        ifc.d_mem_wdata = {16{8'h55}};
        serve(2, rnd128(), w, ga);
        chk("t3_pmem_write", 128'(obs_pw),     128'(1));
        chk("t3_pmem_read",  128'(obs_pr),     128'(0));
        chk("t3_addr",       128'(obs_addr),   128'(16'h2002));
        chk("t3_wdata",      obs_wdata,        {16{8'h55}});
        chk("t3_d_resp",     128'(obs_d_resp), 128'(1));
        chk("t3_i_resp",     128'(obs_i_resp), 128'(0));
        ifc.d_mem_write = 1'b0;
        step();
        chk("t3_idle_write", 128'(obs_pw),     128'(0));
        chk("t3_idle_resp",  128'(obs_d_resp), 128'(0));

        // Test 2: I read, memory answers in the fifth serving cycle.
        ifc.i_mem_read = 1'b1; ifc.i_mem_address = 16'h1000;
        serve(5, {16{8'hA5}}, w, ga);
        chk("t2_pmem_read", 128'(obs_pr),     128'(1));
        chk("t2_addr",      128'(obs_addr),   128'(16'h1000));
        chk("t2_i_resp",    128'(obs_i_resp), 128'(1));
        chk("t2_d_resp",    128'(obs_d_resp), 128'(0));
        chk("t2_i_rdata",   obs_i_rdata,      {16{8'hA5}});
        ifc.i_mem_read = 1'b0;
        step();
        chk("t2_resp_pulse", 128'(obs_i_resp), 128'(0));

        // Test 4: both requesting continuously; grants alternate D,I,D,I with one idle cycle.
        ifc.i_mem_read = 1'b1; ifc.i_mem_address = 16'h1040;
        ifc.d_mem_read = 1'b1; ifc.d_mem_address = 16'h2080;
        for (int k = 0; k < 4; k++) begin
            serve(2, rnd128(), w, ga);
            chk($sformatf("t4_order%0d", k), 128'(ga),
                (k % 2 == 0) ? 128'(16'h2080) : 128'(16'h1040));
            if (k > 0) chk($sformatf("t4_gap%0d", k), 128'(w), 128'(1));
        end
        ifc.i_mem_read = 1'b0; ifc.d_mem_read = 1'b0;
        step();

        // Test 5: reset during SERVE_D, late pmem_resp right after release is dropped.
        ifc.d_mem_read = 1'b1; ifc.d_mem_address = 16'h2222;
        wait_strobe(w);
        step();
        rst_n = 1'b0; ifc.d_mem_read = 1'b0;
        step();
        rst_n = 1'b1; ifc.pmem_resp = 1'b1; ifc.pmem_rdata = rnd128();
        step();
        chk("t5_d_resp", 128'(obs_d_resp), 128'(0));
        chk("t5_i_resp", 128'(obs_i_resp), 128'(0));
        chk("t5_idle",   128'(obs_pr),     128'(0));
        ifc.pmem_resp = 1'b0;
        ifc.i_mem_read = 1'b1; ifc.i_mem_address = 16'h1234;
        serve(3, rnd128(), w, ga);
        chk("t5_new_grant", 128'(obs_i_resp), 128'(1));
        chk("t5_new_addr",  128'(obs_addr),   128'(16'h1234));
        ifc.i_mem_read = 1'b0;
        step();

`ifdef ARB_PERF_CNT_EN
        // Test 6: five more I grants must leave the 2-bit counter saturated.
        for (int k = 0; k < 5; k++) begin
            ifc.i_mem_read = 1'b1;
            serve(1, rnd128(), w, ga);
            ifc.i_mem_read = 1'b0;
            step();
        end
        chk("t6_i_sat", 128'(ifc.perf_i_grants), 128'(3));
`endif

        // Randomized traffic with random memory latency, then drain.
        wait_left = 0;
        allow_new = 1'b1;
        for (int c = 0; c < 460; c++) begin
            if (c == 400) allow_new = 1'b0;
            step();
            if (ifc.i_mem_read) begin
                if (obs_i_resp) ifc.i_mem_read = 1'b0;
            end else if (allow_new && $urandom_range(0, 3) == 0) begin
                ifc.i_mem_read    = 1'b1;
                ifc.i_mem_address = 16'($urandom);
            end
            if (ifc.d_mem_read || ifc.d_mem_write) begin
                if (obs_d_resp) begin
                    ifc.d_mem_read = 1'b0; ifc.d_mem_write = 1'b0;
                end
            end else if (allow_new && $urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 1) ifc.d_mem_read = 1'b1;
                else ifc.d_mem_write = 1'b1;
                ifc.d_mem_address = 16'($urandom);
                ifc.d_mem_wdata   = rnd128();
            end
            if (ifc.pmem_resp) begin
                ifc.pmem_resp = 1'b0;
            end else if (ifc.pmem_read || ifc.pmem_write) begin
                if (wait_left == 0) begin
                    rd = rnd128();
                    ifc.pmem_resp  = 1'b1;
                    ifc.pmem_rdata = rd;
                    wait_left = $urandom_range(0, 3);
                end else begin
                    wait_left--;
                end
            end
        end
        chk("drain_idle", 128'(obs_pr | obs_pw), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
